// File: rtl/adder_unit.sv
// WIDTH-bit adder with combinational sum/carry/overflow and a registered result path
// that also keeps a saturating count of accepted signed-overflow operations.
module adder_unit #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 in_valid,
  output logic [WIDTH-1:0]     sum,
  output logic                 carry,
  output logic                 overflow,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     sum_q,
  output logic                 carry_q,
  output logic                 overflow_q,
  output logic [CNT_WIDTH-1:0] ovf_count
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  logic [WIDTH:0]         full_sum;
  logic                   out_valid_q, out_valid_d;
  logic [WIDTH-1:0]       res_sum_q, res_sum_d;
  logic                   res_carry_q, res_carry_d;
  logic                   res_ovf_q, res_ovf_d;
  logic [CNT_WIDTH-1:0]   ovf_count_q, ovf_count_d;

  // Datapath stays outside the clocked logic so reset and in_valid never touch it.
  always_comb begin
    full_sum = {1'b0, a} + {1'b0, b};
  end

  assign sum      = full_sum[WIDTH-1:0];
  assign carry    = full_sum[WIDTH];
  assign overflow = (a[WIDTH-1] == b[WIDTH-1]) && (full_sum[WIDTH-1] != a[WIDTH-1]);

  always_comb begin
    out_valid_d = in_valid;
    res_sum_d   = res_sum_q;
    res_carry_d = res_carry_q;
    res_ovf_d   = res_ovf_q;
    ovf_count_d = ovf_count_q;
    if (in_valid) begin
      res_sum_d   = sum;
      res_carry_d = carry;
      res_ovf_d   = overflow;
      if (overflow && (ovf_count_q != CNT_MAX)) begin
        ovf_count_d = ovf_count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      res_sum_q   <= '0;
      res_carry_q <= 1'b0;
      res_ovf_q   <= 1'b0;
      ovf_count_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      res_sum_q   <= res_sum_d;
      res_carry_q <= res_carry_d;
      res_ovf_q   <= res_ovf_d;
      ovf_count_q <= ovf_count_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign sum_q      = res_sum_q;
  assign carry_q    = res_carry_q;
  assign overflow_q = res_ovf_q;
  assign ovf_count  = ovf_count_q;

endmodule

// File: tb/tb_adder_unit.sv
// Scoreboard bench for adder_unit: a 32-bit/16-bit-counter instance plus a
// CNT_WIDTH=2 instance used to exercise counter saturation.
module tb_adder_unit;

  typedef struct {
    logic [31:0] s;
    logic        c;
    logic        o;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [31:0] a, b;
  logic        in_valid;
  logic [31:0] sum, sum_q;
  logic        carry, overflow, out_valid, carry_q, overflow_q;
  logic [15:0] ovf_count;

  logic        rst2;
  logic [31:0] a2, b2;
  logic        in_valid2;
  logic [31:0] sum2, sum_q2;
  logic        carry2, overflow2, out_valid2, carry_q2, overflow_q2;
  logic [1:0]  ovf_count2;

  int   n_cmp  = 0;
  int   n_fail = 0;
  exp_t sb[$];
  exp_t last_exp;
  int   exp_cnt;

  adder_unit #(.WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .in_valid(in_valid),
    .sum(sum), .carry(carry), .overflow(overflow),
    .out_valid(out_valid), .sum_q(sum_q), .carry_q(carry_q),
    .overflow_q(overflow_q), .ovf_count(ovf_count)
  );

  adder_unit #(.WIDTH(32), .CNT_WIDTH(2)) dut_sat (
    .clk(clk), .rst(rst2), .a(a2), .b(b2), .in_valid(in_valid2),
    .sum(sum2), .carry(carry2), .overflow(overflow2),
    .out_valid(out_valid2), .sum_q(sum_q2), .carry_q(carry_q2),
    .overflow_q(overflow_q2), .ovf_count(ovf_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: 33-bit unsigned add, overflow from operand/result sign bits.
  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y);
    logic [32:0] full;
    exp_t e;
    full = {1'b0, x} + {1'b0, y};
    e.s  = full[31:0];
    e.c  = full[32];
    e.o  = (x[31] == y[31]) && (full[31] != x[31]);
    return e;
  endfunction

  // Advance one clock, land 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; a = 32'h7FFF_FFFF; b = 32'h1;
    rst2 = 1'b1; in_valid2 = 1'b1; a2 = 32'h7FFF_FFFF; b2 = 32'h1;
    tick();
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (sum_q !== 32'h0) begin n_fail++; $display("FAIL reset_sum_q got %h want 0", sum_q); end
    n_cmp++; if (carry_q !== 1'b0) begin n_fail++; $display("FAIL reset_carry_q got %b want 0", carry_q); end
    n_cmp++; if (overflow_q !== 1'b0) begin n_fail++; $display("FAIL reset_overflow_q got %b want 0", overflow_q); end
    n_cmp++; if (ovf_count !== 16'd0) begin n_fail++; $display("FAIL reset_ovf_count got %0d want 0", ovf_count); end
    n_cmp++; if (ovf_count2 !== 2'd0) begin n_fail++; $display("FAIL reset_ovf_count2 got %0d want 0", ovf_count2); end
    rst = 1'b0; in_valid = 1'b0; rst2 = 1'b0; in_valid2 = 1'b0;
    sb.delete();
    last_exp = '{s: 32'h0, c: 1'b0, o: 1'b0};
    exp_cnt  = 0;
    $display("reset: done");
  endtask

  task automatic test_comb();
    logic [31:0] ta [6];
    logic [31:0] tb_ [6];
    exp_t e;
    ta[0] = 32'h1;         tb_[0] = 32'h2;
    ta[1] = 32'hFFFF_FFFF; tb_[1] = 32'h1;
    ta[2] = 32'h7FFF_FFFF; tb_[2] = 32'h7FFF_FFFF;
    ta[3] = 32'h8000_0000; tb_[3] = 32'hFFFF_FFFF;
    ta[4] = 32'h1234_5678; tb_[4] = 32'h8765_4321;
    ta[5] = 32'hFFFF_FFFF; tb_[5] = 32'hFFFF_FFFF;
    in_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      a = ta[i]; b = tb_[i];
      e = model(ta[i], tb_[i]);
      #1;
      $display("comb: a=%h b=%h sum=%h carry=%b ovf=%b", a, b, sum, carry, overflow);
      n_cmp++; if (sum !== e.s) begin n_fail++; $display("FAIL comb_sum[%0d] got %h want %h", i, sum, e.s); end
      n_cmp++; if (carry !== e.c) begin n_fail++; $display("FAIL comb_carry[%0d] got %b want %b", i, carry, e.c); end
      n_cmp++; if (overflow !== e.o) begin n_fail++; $display("FAIL comb_overflow[%0d] got %b want %b", i, overflow, e.o); end
    end
    // Literal checks of the two directed vectors.
    a = 32'h1; b = 32'h2; #1;
    n_cmp++; if (sum !== 32'd3 || carry !== 1'b0 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL comb_1p2 got %h/%b/%b want 00000003/0/0", sum, carry, overflow); end
    a = 32'hFFFF_FFFF; b = 32'h1; #1;
    n_cmp++; if (sum !== 32'h0 || carry !== 1'b1 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL comb_ffp1 got %h/%b/%b want 00000000/1/0", sum, carry, overflow); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL comb_no_valid got %b want 0", out_valid); end
    tick();
  endtask

  task automatic test_single();
    exp_t e;
    a = 32'h7FFF_FFFF; b = 32'h1; in_valid = 1'b1;
    #1;
    n_cmp++; if (sum !== 32'h8000_0000 || overflow !== 1'b1) begin
      n_fail++; $display("FAIL single_comb got %h/%b want 80000000/1", sum, overflow); end
    sb.push_back(model(a, b));
    exp_cnt++;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (sb.size() == 0) begin n_fail++; $display("FAIL single_sb got empty want 1 entry"); end
    else begin
      e = sb.pop_front();
      last_exp = e;
      $display("single: out_valid=%b sum_q=%h ovf_q=%b cnt=%0d", out_valid, sum_q, overflow_q, ovf_count);
      n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_out_valid got %b want 1", out_valid); end
      n_cmp++; if (sum_q !== 32'h8000_0000) begin n_fail++; $display("FAIL single_sum_q got %h want 80000000", sum_q); end
      n_cmp++; if (overflow_q !== 1'b1) begin n_fail++; $display("FAIL single_overflow_q got %b want 1", overflow_q); end
      n_cmp++; if (ovf_count !== 16'(exp_cnt)) begin n_fail++; $display("FAIL single_ovf_count got %0d want %0d", ovf_count, exp_cnt); end
    end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_drop got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] xa [3];
    logic [31:0] xb [3];
    logic [31:0] want_s [3];
    logic        want_c [3];
    exp_t e;
    xa[0] = 32'd5;         xb[0] = 32'd6;         want_s[0] = 32'd11; want_c[0] = 1'b0;
    xa[1] = 32'h8000_0000; xb[1] = 32'h8000_0000; want_s[1] = 32'd0;  want_c[1] = 1'b1;
    xa[2] = 32'd0;         xb[2] = 32'd0;         want_s[2] = 32'd0;  want_c[2] = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    exp_cnt = 0; sb.delete();
    for (int i = 0; i < 3; i++) begin
      a = xa[i]; b = xb[i]; in_valid = 1'b1;
      e = model(xa[i], xb[i]);
      sb.push_back(e);
      if (e.o) exp_cnt++;
      tick();
      n_cmp++; if (sb.size() == 0) begin n_fail++; $display("FAIL b2b_sb[%0d] got empty want entry", i); end
      else begin
        e = sb.pop_front();
        last_exp = e;
        $display("b2b[%0d]: out_valid=%b sum_q=%h carry_q=%b ovf_q=%b", i, out_valid, sum_q, carry_q, overflow_q);
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_out_valid[%0d] got %b want 1", i, out_valid); end
        n_cmp++; if (sum_q !== want_s[i]) begin n_fail++; $display("FAIL b2b_sum_q[%0d] got %h want %h", i, sum_q, want_s[i]); end
        n_cmp++; if (carry_q !== want_c[i]) begin n_fail++; $display("FAIL b2b_carry_q[%0d] got %b want %b", i, carry_q, want_c[i]); end
        n_cmp++; if (overflow_q !== e.o) begin n_fail++; $display("FAIL b2b_overflow_q[%0d] got %b want %b", i, overflow_q, e.o); end
      end
    end
    in_valid = 1'b0;
    n_cmp++; if (ovf_count !== 16'd1) begin n_fail++; $display("FAIL b2b_ovf_count got %0d want 1", ovf_count); end
  endtask

  task automatic test_hold();
    a = 32'h7FFF_FFFF; b = 32'h7FFF_FFFF; in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      $display("hold[%0d]: out_valid=%b sum_q=%h cnt=%0d", i, out_valid, sum_q, ovf_count);
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL hold_out_valid[%0d] got %b want 0", i, out_valid); end
      n_cmp++; if (sum_q !== last_exp.s || carry_q !== last_exp.c || overflow_q !== last_exp.o) begin
        n_fail++; $display("FAIL hold_regs[%0d] got %h/%b/%b want %h/%b/%b", i, sum_q, carry_q, overflow_q,
                          last_exp.s, last_exp.c, last_exp.o); end
      n_cmp++; if (ovf_count !== 16'(exp_cnt)) begin n_fail++; $display("FAIL hold_ovf_count[%0d] got %0d want %0d", i, ovf_count, exp_cnt); end
    end
  endtask

  task automatic test_random();
    exp_t e;
    logic v;
    for (int i = 0; i < 40; i++) begin
      v = ($urandom_range(3, 0) != 0);
      a = $urandom; b = $urandom;
      if ($urandom_range(3, 0) == 0) begin a = {1'b0, a[30:0]} | 32'h4000_0000; b = {1'b0, b[30:0]} | 32'h4000_0000; end
      in_valid = v;
      if (v) begin
        e = model(a, b);
        sb.push_back(e);
        if (e.o) exp_cnt++;
      end
      tick();
      if (v) begin
        n_cmp++; if (sb.size() == 0) begin n_fail++; $display("FAIL rand_sb[%0d] got empty want entry", i); end
        else begin
          e = sb.pop_front();
          last_exp = e;
          n_cmp++; if (out_valid !== 1'b1 || sum_q !== e.s || carry_q !== e.c || overflow_q !== e.o) begin
            n_fail++; $display("FAIL rand_op[%0d] got v=%b %h/%b/%b want v=1 %h/%b/%b", i, out_valid,
                              sum_q, carry_q, overflow_q, e.s, e.c, e.o); end
        end
      end else begin
        n_cmp++; if (out_valid !== 1'b0 || sum_q !== last_exp.s) begin
          n_fail++; $display("FAIL rand_idle[%0d] got v=%b sum_q=%h want v=0 sum_q=%h", i, out_valid, sum_q, last_exp.s); end
      end
      n_cmp++; if (ovf_count !== 16'(exp_cnt)) begin n_fail++; $display("FAIL rand_ovf_count[%0d] got %0d want %0d", i, ovf_count, exp_cnt); end
      $display("rand[%0d]: in_valid=%b out_valid=%b sum_q=%h cnt=%0d", i, v, out_valid, sum_q, ovf_count);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_priority();
    exp_t e;
    a = 32'h7FFF_FFFF; b = 32'h7FFF_FFFF; in_valid = 1'b1; rst = 1'b1;
    e = model(a, b);
    #1;
    n_cmp++; if (sum !== e.s || overflow !== e.o) begin
      n_fail++; $display("FAIL rstpri_comb_pre got %h/%b want %h/%b", sum, overflow, e.s, e.o); end
    tick();
    rst = 1'b0; in_valid = 1'b0;
    sb.delete(); exp_cnt = 0; last_exp = '{s: 32'h0, c: 1'b0, o: 1'b0};
    $display("rstpri: out_valid=%b sum_q=%h cnt=%0d sum=%h", out_valid, sum_q, ovf_count, sum);
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstpri_out_valid got %b want 0", out_valid); end
    n_cmp++; if (sum_q !== 32'h0 || overflow_q !== 1'b0) begin n_fail++; $display("FAIL rstpri_regs got %h/%b want 0/0", sum_q, overflow_q); end
    n_cmp++; if (ovf_count !== 16'd0) begin n_fail++; $display("FAIL rstpri_ovf_count got %0d want 0", ovf_count); end
    n_cmp++; if (sum !== e.s) begin n_fail++; $display("FAIL rstpri_comb_post got %h want %h", sum, e.s); end
  endtask

  task automatic test_saturation();
    logic [1:0] want [5];
    want[0] = 2'd1; want[1] = 2'd2; want[2] = 2'd3; want[3] = 2'd3; want[4] = 2'd3;
    rst2 = 1'b1; tick(); rst2 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a2 = 32'h7FFF_FFFF; b2 = 32'(i + 1); in_valid2 = 1'b1;
      tick();
      $display("sat[%0d]: out_valid=%b ovf_q=%b cnt=%0d", i, out_valid2, overflow_q2, ovf_count2);
      n_cmp++; if (ovf_count2 !== want[i]) begin n_fail++; $display("FAIL sat_count[%0d] got %0d want %0d", i, ovf_count2, want[i]); end
      n_cmp++; if (out_valid2 !== 1'b1 || overflow_q2 !== 1'b1) begin
        n_fail++; $display("FAIL sat_out[%0d] got %b/%b want 1/1", i, out_valid2, overflow_q2); end
    end
    in_valid2 = 1'b0;
    tick();
    n_cmp++; if (ovf_count2 !== 2'd3) begin n_fail++; $display("FAIL sat_idle got %0d want 3", ovf_count2); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0;
    rst2 = 1'b1; in_valid2 = 1'b0; a2 = '0; b2 = '0;
    exp_cnt = 0;
    last_exp = '{s: 32'h0, c: 1'b0, o: 1'b0};
    test_reset();
    test_comb();
    test_single();
    test_back_to_back();
    test_hold();
    test_random();
    test_reset_priority();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
